// File: rtl/oam_dma_arbiter_if.sv
// CPU-side and memory-side bus bundle for the OAM DMA arbiter.
// The arbiter takes the slave view; the CPU/memory side takes the master view.
`timescale 1ns/1ps

interface oam_dma_arbiter_if;
    logic        cpu_rd;
    logic        cpu_wen;
    logic [15:0] cpu_r_addr;
    logic [15:0] cpu_w_addr;
    logic [7:0]  cpu_w_data;
    logic [7:0]  cpu_r_data;
    logic        cpu_wait;
    logic        mem_wen;
    logic [15:0] mem_r_addr;
    logic [15:0] mem_w_addr;
    logic [7:0]  mem_w_data;
    logic [7:0]  mem_r_data;

    modport slave (
        input  cpu_rd, cpu_wen, cpu_r_addr, cpu_w_addr, cpu_w_data, mem_r_data,
        output cpu_r_data, cpu_wait, mem_wen, mem_r_addr, mem_w_addr, mem_w_data
    );

    modport master (
        output cpu_rd, cpu_wen, cpu_r_addr, cpu_w_addr, cpu_w_data, mem_r_data,
        input  cpu_r_data, cpu_wait, mem_wen, mem_r_addr, mem_w_addr, mem_w_data
    );
endinterface

// File: rtl/oam_dma_arbiter.sv
// Owns the DMA register and sequences OAM DMA, sharing one memory port between
// the DMA engine and CPU accesses (only HRAM stays reachable during a transfer).
`timescale 1ns/1ps

module oam_dma_arbiter #(
    parameter int          CYCLES_PER_BYTE = 4,
    parameter int          OAM_LEN         = 160,
    parameter logic [15:0] DMA_REG_ADDR    = 16'hFF46
) (
    input  logic               clk,
    input  logic               rst,
    oam_dma_arbiter_if.slave   bus,
    output logic               dma_busy,
    output logic               dma_active
);

    localparam int              PHASE_W    = (CYCLES_PER_BYTE > 1) ? $clog2(CYCLES_PER_BYTE) : 1;
    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(CYCLES_PER_BYTE - 1);
    localparam logic [7:0]      IDX_LAST   = 8'(OAM_LEN - 1);

    typedef enum logic [1:0] {IDLE, SETUP, XFER} state_t;

    state_t               state, state_n;
    logic [7:0]           dma_reg, dma_reg_n;
    logic [PHASE_W-1:0]   phase, phase_n;
    logic [7:0]           idx, idx_n;

    logic reg_wr, reg_rd, slot, hram_rd, hram_wr, hram_req;

    function automatic logic is_hram(input logic [15:0] addr);
        return (addr >= 16'hFF80) && (addr <= 16'hFFFE);
    endfunction

    assign reg_wr   = bus.cpu_wen && (bus.cpu_w_addr == DMA_REG_ADDR);
    assign reg_rd   = (bus.cpu_r_addr == DMA_REG_ADDR);
    assign slot     = (state == XFER) && (phase == PHASE_LAST);
    assign hram_rd  = is_hram(bus.cpu_r_addr);
    assign hram_wr  = is_hram(bus.cpu_w_addr);
    assign hram_req = (bus.cpu_rd && hram_rd) || (bus.cpu_wen && hram_wr);

    assign dma_busy   = (state != IDLE);
    assign dma_active = (state == XFER);

    // NOTE: state registers use non-blocking assignments so every register
    // samples the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            dma_reg <= 8'hFF;
            phase   <= '0;
            idx     <= '0;
        end else begin
            state   <= state_n;
            dma_reg <= dma_reg_n;
            phase   <= phase_n;
            idx     <= idx_n;
        end
    end

    // NOTE: every signal written here gets a default first, so no path through
    // the case can leave one unassigned and infer a latch.
    always_comb begin
        state_n        = state;
        dma_reg_n      = dma_reg;
        phase_n        = phase;
        idx_n          = idx;
        bus.mem_r_addr = bus.cpu_r_addr;
        bus.mem_w_addr = bus.cpu_w_addr;
        bus.mem_w_data = bus.cpu_w_data;
        bus.mem_wen    = bus.cpu_wen && !reg_wr;
        bus.cpu_r_data = reg_rd ? dma_reg : bus.mem_r_data;
        bus.cpu_wait   = 1'b0;

        case (state)
            SETUP: begin
                if (phase == PHASE_LAST) begin
                    phase_n = '0;
                    state_n = XFER;
                end else begin
                    phase_n = phase + PHASE_W'(1);
                end
            end
            XFER: begin
                if (slot) begin
                    // DMA owns the port; the source page is used as-is.
                    bus.mem_r_addr = {dma_reg, idx};
                    bus.mem_w_addr = 16'hFE00 + {8'h00, idx};
                    bus.mem_w_data = bus.mem_r_data;
                    bus.mem_wen    = 1'b1;
                    bus.cpu_wait   = hram_req;
                    bus.cpu_r_data = reg_rd ? dma_reg : 8'hFF;
                    phase_n        = '0;
                    if (idx == IDX_LAST) begin
                        idx_n   = '0;
                        state_n = IDLE;
                    end else begin
                        idx_n = idx + 8'd1;
                    end
                end else begin
                    phase_n = phase + PHASE_W'(1);
                    if (bus.cpu_wen && !hram_wr)
                        bus.mem_wen = 1'b0;
                    if (!reg_rd && !hram_rd)
                        bus.cpu_r_data = 8'hFF;
                end
            end
            default: ;
        endcase

        // A register write restarts from any state; the slot's write above still lands.
        if (reg_wr) begin
            dma_reg_n = bus.cpu_w_data;
            state_n   = SETUP;
            phase_n   = '0;
            idx_n     = '0;
        end
    end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Scoreboarded bench for oam_dma_arbiter: one instance with 4 clocks per byte,
// one with 1 clock per byte, each with its own behavioural memory.
`timescale 1ns/1ps

module tb_oam_dma_arbiter;

    localparam int OAM_LEN = 160;

    typedef struct {
        int          cyc;
        logic [15:0] addr;
        logic [7:0]  data;
    } exp_t;

    logic clk = 1'b0;
    logic rst4, rst1;
    logic busy4, active4, busy1, active1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] mem4 [0:65535];
    logic [7:0] mem1 [0:65535];

    exp_t sb4[$];
    exp_t sb1[$];

    int   rise4 = -1, fall4 = -1, rise1 = -1, fall1 = -1;
    logic prev4 = 1'b0, prev1 = 1'b0;

    oam_dma_arbiter_if bus4();
    oam_dma_arbiter_if bus1();

    oam_dma_arbiter #(.CYCLES_PER_BYTE(4), .OAM_LEN(OAM_LEN), .DMA_REG_ADDR(16'hFF46)) u_dut4 (
        .clk(clk), .rst(rst4), .bus(bus4.slave), .dma_busy(busy4), .dma_active(active4)
    );

    oam_dma_arbiter #(.CYCLES_PER_BYTE(1), .OAM_LEN(OAM_LEN), .DMA_REG_ADDR(16'hFF46)) u_dut1 (
        .clk(clk), .rst(rst1), .bus(bus1.slave), .dma_busy(busy1), .dma_active(active1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) if (bus4.mem_wen) mem4[bus4.mem_w_addr] <= bus4.mem_w_data;
    always @(posedge clk) if (bus1.mem_wen) mem1[bus1.mem_w_addr] <= bus1.mem_w_data;
    assign bus4.mem_r_data = mem4[bus4.mem_r_addr];
    assign bus1.mem_r_data = mem1[bus1.mem_r_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] src_byte(input logic [7:0] page, input int i);
        logic [7:0] k;
        k = 8'(i);
        case (page)
            8'hC0:   return k ^ 8'h5A;
            8'hD0:   return k ^ 8'hA5;
            8'hE0:   return k ^ 8'h33;
            default: return 8'h00;
        endcase
    endfunction

    // Each OAM-page write pops the next expected (cycle, address, data) entry.
    always @(negedge clk) begin : mon4
        exp_t e;
        if (!rst4 && bus4.mem_wen && bus4.mem_w_addr[15:8] == 8'hFE) begin
            check("dma4_expected", 32'(sb4.size() != 0), 1);
            if (sb4.size() != 0) begin
                e = sb4.pop_front();
                check("dma4_cycle", cyc, e.cyc);
                check("dma4_addr", bus4.mem_w_addr, e.addr);
                check("dma4_data", bus4.mem_w_data, e.data);
            end
        end
        if (busy4 && !prev4) rise4 = cyc;
        if (!busy4 && prev4) fall4 = cyc;
        prev4 = busy4;
    end

    always @(negedge clk) begin : mon1
        exp_t e;
        if (!rst1 && bus1.mem_wen && bus1.mem_w_addr[15:8] == 8'hFE) begin
            check("dma1_expected", 32'(sb1.size() != 0), 1);
            if (sb1.size() != 0) begin
                e = sb1.pop_front();
                check("dma1_cycle", cyc, e.cyc);
                check("dma1_addr", bus1.mem_w_addr, e.addr);
                check("dma1_data", bus1.mem_w_data, e.data);
            end
        end
        if (busy1 && !prev1) rise1 = cyc;
        if (!busy1 && prev1) fall1 = cyc;
        prev1 = busy1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go_to(input int c);
        if (cyc > c) check("schedule", cyc, c);
        while (cyc < c) step();
    endtask

    task automatic idle4();
        bus4.cpu_rd = 1'b0; bus4.cpu_wen = 1'b0;
        bus4.cpu_r_addr = 16'h0000; bus4.cpu_w_addr = 16'h0000; bus4.cpu_w_data = 8'h00;
    endtask

    task automatic idle1();
        bus1.cpu_rd = 1'b0; bus1.cpu_wen = 1'b0;
        bus1.cpu_r_addr = 16'h0000; bus1.cpu_w_addr = 16'h0000; bus1.cpu_w_data = 8'h00;
    endtask

    task automatic wr4(input logic [15:0] addr, input logic [7:0] data);
        bus4.cpu_wen = 1'b1; bus4.cpu_w_addr = addr; bus4.cpu_w_data = data;
        step();
        bus4.cpu_wen = 1'b0;
    endtask

    task automatic wr1(input logic [15:0] addr, input logic [7:0] data);
        bus1.cpu_wen = 1'b1; bus1.cpu_w_addr = addr; bus1.cpu_w_data = data;
        step();
        bus1.cpu_wen = 1'b0;
    endtask

    // Drives the FF46 write for one cycle, then replaces the scoreboard contents
    // with the new transfer (after any slot write of that same cycle was popped).
    task automatic trig4(input logic [7:0] page, output int t);
        bus4.cpu_wen = 1'b1; bus4.cpu_w_addr = 16'hFF46; bus4.cpu_w_data = page;
        t = cyc;
        step();
        bus4.cpu_wen = 1'b0;
        sb4.delete();
        for (int i = 0; i < OAM_LEN; i++)
            sb4.push_back('{cyc: t + 8 + 4 * i, addr: 16'(16'hFE00 + i), data: src_byte(page, i)});
    endtask

    task automatic trig1(input logic [7:0] page, output int t);
        bus1.cpu_wen = 1'b1; bus1.cpu_w_addr = 16'hFF46; bus1.cpu_w_data = page;
        t = cyc;
        step();
        bus1.cpu_wen = 1'b0;
        sb1.delete();
        for (int i = 0; i < OAM_LEN; i++)
            sb1.push_back('{cyc: t + 2 + i, addr: 16'(16'hFE00 + i), data: src_byte(page, i)});
    endtask

    task automatic wait_idle4(input int limit);
        int n = 0;
        while (busy4 && n < limit) begin step(); n++; end
        check("dma4_finish", busy4, 0);
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idle1(input int limit);
        int n = 0;
        while (busy1 && n < limit) begin step(); n++; end
        check("dma1_finish", busy1, 0);
        @(negedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t, r, u, n;
        idle4(); idle1();
        rst4 = 1'b0; rst1 = 1'b0;
        #1;
        rst4 = 1'b1; rst1 = 1'b1;
        #2;
        check("rst_busy", busy4, 0);
        check("rst_active", active4, 0);
        check("rst_wait", bus4.cpu_wait, 0);
        bus4.cpu_r_addr = 16'hFF46;
        #1 check("rst_reg_read", bus4.cpu_r_data, 8'hFF);
        bus4.cpu_r_addr = 16'h1234;
        #1 check("rst_pass_raddr", bus4.mem_r_addr, 16'h1234);
        step(); step();
        rst4 = 1'b0; rst1 = 1'b0;
        step();

        // Preload through the IDLE pass-through path.
        for (int i = 0; i < OAM_LEN; i++) begin
            wr4(16'(16'hC000 + i), src_byte(8'hC0, i));
            wr4(16'(16'hD000 + i), src_byte(8'hD0, i));
            wr4(16'(16'hE000 + i), src_byte(8'hE0, i));
            wr1(16'(16'hC000 + i), src_byte(8'hC0, i));
        end
        wr4(16'hFF80, 8'h3C);
        wr4(16'hC100, 8'h11);
        wr1(16'hFF80, 8'h3C);
        check("preload_write", mem4[16'hC005], src_byte(8'hC0, 5));
        bus4.cpu_rd = 1'b1; bus4.cpu_r_addr = 16'hC003;
        #1 check("idle_read", bus4.cpu_r_data, src_byte(8'hC0, 3));
        idle4();
        step();

        // Basic transfer with CPU traffic around one slot.
        trig4(8'hC0, t);
        check("setup_busy", busy4, 1);
        check("setup_active", active4, 0);
        go_to(t + 9);
        check("xfer_active", active4, 1);
        go_to(t + 45);
        bus4.cpu_rd = 1'b1; bus4.cpu_r_addr = 16'h1234;
        bus4.cpu_wen = 1'b1; bus4.cpu_w_addr = 16'hC100; bus4.cpu_w_data = 8'h77;
        #1;
        check("blocked_read", bus4.cpu_r_data, 8'hFF);
        check("blocked_wait", bus4.cpu_wait, 0);
        check("blocked_wen", bus4.mem_wen, 0);
        step();
        bus4.cpu_wen = 1'b0; bus4.cpu_r_addr = 16'hFF80;
        #1;
        check("hram_read", bus4.cpu_r_data, 8'h3C);
        check("hram_read_wait", bus4.cpu_wait, 0);
        step();
        bus4.cpu_r_addr = 16'hFF46;
        #1 check("xfer_reg_read", bus4.cpu_r_data, 8'hC0);
        step();
        bus4.cpu_rd = 1'b0;
        bus4.cpu_wen = 1'b1; bus4.cpu_w_addr = 16'hFF90; bus4.cpu_w_data = 8'hAB;
        #1;
        check("collide_wait", bus4.cpu_wait, 1);
        check("collide_dma_addr", bus4.mem_w_addr, 16'hFE0A);
        step();
        #1;
        check("collide_retry_wait", bus4.cpu_wait, 0);
        check("collide_retry_addr", bus4.mem_w_addr, 16'hFF90);
        check("collide_retry_wen", bus4.mem_wen, 1);
        step();
        idle4();
        #1 check("collide_hram_value", mem4[16'hFF90], 8'hAB);
        wait_idle4(1000);
        check("basic_busy_rise", rise4, t + 1);
        check("basic_busy_fall", fall4, t + 161 * 4 + 1);
        check("dropped_write", mem4[16'hC100], 8'h11);
        for (int i = 0; i < OAM_LEN; i++)
            check("basic_oam", mem4[16'hFE00 + i], src_byte(8'hC0, i));
        check("basic_sb_empty", sb4.size(), 0);

        // Restart from E0 (no remap) to D0 in the slot of byte 50.
        step();
        trig4(8'hE0, t);
        go_to(t + 208);
        check("restart_in_xfer", active4, 1);
        trig4(8'hD0, r);
        check("restart_setup", active4, 0);
        wait_idle4(1000);
        check("restart_busy_rise", rise4, t + 1);
        check("restart_busy_fall", fall4, r + 161 * 4 + 1);
        for (int i = 0; i < OAM_LEN; i++)
            check("restart_oam", mem4[16'hFE00 + i], src_byte(8'hD0, i));
        check("restart_sb_empty", sb4.size(), 0);

        // Asynchronous reset while idx is 37.
        step();
        trig4(8'hC0, t);
        go_to(t + 154);
        rst4 = 1'b1;
        bus4.cpu_r_addr = 16'hFF46;
        #1;
        check("midrst_busy", busy4, 0);
        check("midrst_active", active4, 0);
        check("midrst_reg_read", bus4.cpu_r_data, 8'hFF);
        sb4.delete();
        step(); step();
        rst4 = 1'b0;
        idle4();
        repeat (100) step();
        check("midrst_still_idle", busy4, 0);
        check("midrst_last_byte", mem4[16'hFE24], src_byte(8'hC0, 36));
        check("midrst_untouched", mem4[16'hFE25], src_byte(8'hD0, 37));

        // One clock per byte: HRAM read held across the whole transfer.
        trig1(8'hC0, u);
        go_to(u + 5);
        bus1.cpu_rd = 1'b1; bus1.cpu_r_addr = 16'hFF80;
        #1 check("cpb1_wait_start", bus1.cpu_wait, 1);
        n = 0;
        while (bus1.cpu_wait && n < 400) begin step(); n++; end
        check("cpb1_wait_released", bus1.cpu_wait, 0);
        check("cpb1_release_cycle", cyc, u + 162);
        check("cpb1_read_data", bus1.cpu_r_data, 8'h3C);
        idle1();
        wait_idle1(400);
        check("cpb1_busy_rise", rise1, u + 1);
        check("cpb1_busy_fall", fall1, u + 162);
        for (int i = 0; i < OAM_LEN; i++)
            check("cpb1_oam", mem1[16'hFE00 + i], src_byte(8'hC0, i));
        check("cpb1_sb_empty", sb1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/oam_dma_arbiter.md
Name: oam_dma_arbiter

Overview:
Sits between the SM83 core's memory port and the shared memory (wen, r_addr, w_addr, w_data, combinational r_data). It owns the DMA register at FF46 and sequences OAM DMA: a copy of OAM_LEN bytes from page V<<8 to FE00. During DMA it arbitrates the single memory between the DMA engine and CPU HRAM accesses.

Parameters:
CYCLES_PER_BYTE, 4, clocks per transferred byte (>=1)
OAM_LEN, 160, bytes per DMA
DMA_REG_ADDR, 16'hFF46, DMA trigger/readback register address

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
cpu_rd  in  1  CPU read strobe
cpu_wen  in  1  CPU write strobe
cpu_r_addr  in  16  CPU read address (addr_t)
cpu_w_addr  in  16  CPU write address (addr_t)
cpu_w_data  in  8  CPU write data (data_t)
cpu_r_data  out  8  CPU read data, combinational
cpu_wait  out  1  CPU must hold its request this cycle
mem_wen  out  1  memory write enable
mem_r_addr  out  16  memory read address
mem_w_addr  out  16  memory write address
mem_w_data  out  8  memory write data
mem_r_data  in  8  memory read data (combinational)
dma_busy  out  1  state is SETUP or XFER
dma_active  out  1  state is XFER

Behaviour:
- Registers: state {IDLE, SETUP, XFER}, dma_reg[7:0], phase counter (0..CYCLES_PER_BYTE-1), idx (0..OAM_LEN-1).
- Reset (async, rst=1): state=IDLE, dma_reg=8'hFF, phase=0, idx=0. Outputs settle immediately to IDLE values: dma_busy=0, dma_active=0, cpu_wait=0, mem_* = CPU pass-through.
- FF46 access is accepted in every state and is never forwarded to memory.
  - CPU write to DMA_REG_ADDR: dma_reg<=cpu_w_data; state<=SETUP; phase<=0; idx<=0. mem_wen=0 that cycle.
  - CPU read of DMA_REG_ADDR: cpu_r_data=dma_reg.
- A write to FF46 during SETUP or XFER restarts the transfer with the new source. Bytes already copied stay in memory.
- IDLE: full pass-through. mem_r_addr=cpu_r_addr, mem_w_addr=cpu_w_addr, mem_w_data=cpu_w_data, mem_wen=cpu_wen, cpu_r_data=mem_r_data.
- SETUP: lasts CYCLES_PER_BYTE clocks with pass-through as in IDLE. When phase wraps to 0, go to XFER.
- XFER:
  - phase increments each clock and wraps at CYCLES_PER_BYTE-1.
  - The DMA slot is phase==CYCLES_PER_BYTE-1. In the slot: mem_r_addr={dma_reg,idx[7:0]}, mem_w_addr=16'hFE00+idx, mem_w_data=mem_r_data, mem_wen=1.
  - After the slot, idx increments. After the slot with idx==OAM_LEN-1, state<=IDLE.
- Source address is {dma_reg,8'h00}+idx used literally, with no remapping of E0-FF.
- CPU during XFER, HRAM = FF80..FFFE:
  - Non-HRAM, non-FF46 read: cpu_r_data=8'hFF, no wait.
  - Non-HRAM, non-FF46 write: dropped, no wait.
  - HRAM access outside the DMA slot: passes through as in IDLE.
  - HRAM access (cpu_rd or cpu_wen) in the DMA slot: cpu_wait=1, CPU access not performed, DMA wins. The CPU holds its request and completes next cycle.
  - With CYCLES_PER_BYTE=1, HRAM access waits for the whole XFER.
- cpu_wait=0 in IDLE/SETUP and whenever no HRAM request is present.
- Timing: FF46 write sampled at edge t. SETUP runs t+1..t+CPB. First DMA write at cycle t+2*CPB. Last DMA write at t+(OAM_LEN+1)*CPB. dma_busy falls the following cycle.
- Simultaneous FF46 write and DMA slot: the restart wins and the slot's write still occurs. Both write ports are distinct because the FF46 write is not forwarded.

Test Plan:
- Reset mid-XFER (idx=37): all state cleared the same cycle. dma_busy=0, read FF46 returns 8'hFF, no further FE-page writes.
- Basic DMA, CPB=4: preload C000..C09F = i^8'h5A, write 8'hC0 to FF46 at cycle 10. FE00..FE9F match. First mem_wen at cycle 18, last at 654. dma_busy high 11..654.
- Blocking: during XFER, read 8'h1234 returns 8'hFF; write 8'h77 to C100 leaves it unchanged. Read FF80 in a non-slot phase returns stored value with cpu_wait=0.
- HRAM collision: write 8'hAB to FF90 in the DMA slot. cpu_wait=1 for one cycle, FF90=8'hAB the next cycle, DMA byte still written correctly.
- Restart: at idx=50 write 8'hD0 to FF46. SETUP re-entered. FE00..FE9F end up equal to D000..D09F. Total busy equals (OAM_LEN+1)*CPB clocks from the restart.
- CPB=1: 161-cycle busy window; an HRAM read held across XFER completes on the first IDLE cycle.
